// File: rtl/sd_spi_block_rx.sv
// SD SPI-mode single data block receiver: token hunt, MSB-first byte stream, CRC16 check.
// Optional CRC16 engine built only when SD_RX_CRC_CHECK_EN is defined; otherwise CRC bits are consumed and accepted.
module sd_spi_block_rx #(
  parameter int         BLOCK_BYTES         = 512,
  parameter int         TOKEN_TIMEOUT_BYTES = 100,
  parameter logic [7:0] START_TOKEN         = 8'hFE,
  localparam int        IW                  = $clog2(BLOCK_BYTES),
  localparam int        TW                  = $clog2(TOKEN_TIMEOUT_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          bit_strobe,
  input  logic          sd_data0,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  output logic [IW-1:0] byte_index,
  output logic          busy,
  output logic          done,
  output logic          crc_ok,
  output logic          err_crc,
  output logic          err_token,
  output logic          err_timeout,
  output logic [3:0]    err_code,
  output logic [15:0]   crc_rx,
  output logic [15:0]   crc_calc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TOKEN,
    S_DATA,
    S_CRC,
    S_FINISH
  } state_t;

  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [IW-1:0] byte_cnt;
  logic [15:0]   crc_cur;
  logic [7:0]    byte_nxt;
  logic [15:0]   crc_rx_nxt;
  logic          byte_end;
  logic          crc_en;

  assign byte_nxt   = {shreg[6:0], sd_data0};
  assign crc_rx_nxt = {crc_rx[14:0], sd_data0};
  assign byte_end   = bit_strobe && (bit_cnt == 3'd7);

`ifdef SD_RX_CRC_CHECK_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc16_bit(input logic [15:0] c, input logic d);
    logic fb;
    fb = c[15] ^ d;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Seeded on the start token so only payload bits contribute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 16'h0000;
    end else if (state == S_WAIT_TOKEN && byte_end && byte_nxt == START_TOKEN
                 && byte_nxt != 8'hFF) begin
      crc <= 16'h0000;
    end else if (state == S_DATA && bit_strobe) begin
      crc <= crc16_bit(crc, sd_data0);
    end
  end

  assign crc_cur = crc;
  assign crc_en  = 1'b1;
`else
  assign crc_cur = 16'h0000;
  assign crc_en  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      shreg       <= 8'h00;
      bit_cnt     <= 3'd0;
      to_cnt      <= '0;
      byte_cnt    <= '0;
      byte_out    <= 8'h00;
      byte_valid  <= 1'b0;
      byte_index  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      crc_ok      <= 1'b0;
      err_crc     <= 1'b0;
      err_token   <= 1'b0;
      err_timeout <= 1'b0;
      err_code    <= 4'h0;
      crc_rx      <= 16'h0000;
      crc_calc    <= 16'h0000;
    end else begin
      byte_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          // A strobe arriving with start is deliberately not counted.
          if (start) begin
            state       <= S_WAIT_TOKEN;
            busy        <= 1'b1;
            crc_ok      <= 1'b0;
            err_crc     <= 1'b0;
            err_token   <= 1'b0;
            err_timeout <= 1'b0;
            err_code    <= 4'h0;
            crc_rx      <= 16'h0000;
            crc_calc    <= 16'h0000;
            shreg       <= 8'h00;
            bit_cnt     <= 3'd0;
            to_cnt      <= '0;
            byte_cnt    <= '0;
          end
        end

        S_WAIT_TOKEN: begin
          if (bit_strobe) begin
            shreg   <= byte_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_nxt == 8'hFF) begin
                to_cnt <= to_cnt + TW'(1);
                if (to_cnt == TW'(TOKEN_TIMEOUT_BYTES - 1)) begin
                  err_timeout <= 1'b1;
                  done        <= 1'b1;
                  state       <= S_FINISH;
                end
              end else if (byte_nxt == START_TOKEN) begin
                byte_cnt <= '0;
                state    <= S_DATA;
              end else begin
                err_token <= 1'b1;
                err_code  <= (byte_nxt[7:4] == 4'h0) ? byte_nxt[3:0] : 4'hF;
                done      <= 1'b1;
                state     <= S_FINISH;
              end
            end
          end
        end

        S_DATA: begin
          if (bit_strobe) begin
            shreg   <= byte_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_out   <= byte_nxt;
              byte_index <= byte_cnt;
              byte_valid <= 1'b1;
              if (byte_cnt == IW'(BLOCK_BYTES - 1)) begin
                byte_cnt <= '0;
                state    <= S_CRC;
              end else begin
                byte_cnt <= byte_cnt + IW'(1);
              end
            end
          end
        end

        S_CRC: begin
          if (bit_strobe) begin
            shreg   <= byte_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            crc_rx  <= crc_rx_nxt;
            // byte_cnt[0] distinguishes the high and low CRC bytes.
            if (bit_cnt == 3'd7) begin
              if (byte_cnt[0]) begin
                crc_calc <= crc_cur;
                crc_ok   <= !crc_en || (crc_rx_nxt == crc_cur);
                err_crc  <= crc_en && (crc_rx_nxt != crc_cur);
                done     <= 1'b1;
                state    <= S_FINISH;
              end else begin
                byte_cnt <= IW'(1);
              end
            end
          end
        end

        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_block_rx.sv
// Directed + randomized bench for sd_spi_block_rx with a byte-level reference model.
`timescale 1ns/1ps
module tb_sd_spi_block_rx;

  localparam int NB = 512;
`ifdef SD_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  localparam int K_OK  = 0;
  localparam int K_CRC = 1;
  localparam int K_TOK = 2;
  localparam int K_TMO = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        bit_strobe = 1'b0;
  logic        sd_data0 = 1'b1;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [8:0]  byte_index;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        err_crc;
  logic        err_token;
  logic        err_timeout;
  logic [3:0]  err_code;
  logic [15:0] crc_rx;
  logic [15:0] crc_calc;

  sd_spi_block_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bit_strobe  (bit_strobe),
    .sd_data0    (sd_data0),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_index  (byte_index),
    .busy        (busy),
    .done        (done),
    .crc_ok      (crc_ok),
    .err_crc     (err_crc),
    .err_token   (err_token),
    .err_timeout (err_timeout),
    .err_code    (err_code),
    .crc_rx      (crc_rx),
    .crc_calc    (crc_calc)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int strobes  = 0;
  int done_strobe = 0;

  logic [8:0]  cap_idx[$];
  logic [7:0]  cap_dat[$];
  logic [7:0]  stream[$];
  logic [7:0]  e_dat[$];
  int          e_kind;
  logic [3:0]  e_code;
  logic [15:0] e_rx;
  logic [15:0] e_calc;

  always @(negedge clk) begin
    if (byte_valid) begin
      cap_idx.push_back(byte_index);
      cap_dat.push_back(byte_out);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Long-division CRC16-CCITT over whole bytes, init 0.
  function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
    logic [15:0] c;
    c = 16'h0000;
    foreach (q[i]) begin
      c = c ^ {q[i], 8'h00};
      for (int b = 0; b < 8; b++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic model();
    int          i;
    int          ffs;
    logic [7:0]  b;
    logic [15:0] c;
    i = 0;
    ffs = 0;
    e_dat.delete();
    e_kind = -1;
    e_code = 4'h0;
    e_rx   = 16'h0000;
    e_calc = 16'h0000;
    while (e_kind < 0 && i < stream.size()) begin
      b = stream[i];
      i++;
      if (b == 8'hFF) begin
        ffs++;
        if (ffs == 100) e_kind = K_TMO;
      end else if (b == 8'hFE) begin
        for (int k = 0; k < NB; k++) e_dat.push_back(stream[i + k]);
        e_rx   = {stream[i + NB], stream[i + NB + 1]};
        c      = crc_of(e_dat);
        e_calc = CRC_EN ? c : 16'h0000;
        e_kind = (!CRC_EN || c == e_rx) ? K_OK : K_CRC;
      end else begin
        e_kind = K_TOK;
        e_code = (b[7:4] == 4'h0) ? b[3:0] : 4'hF;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_strobe = 1'b1;
    sd_data0   = b;
    @(negedge clk);
    bit_strobe = 1'b0;
    sd_data0   = 1'b1;
    strobes++;
    if (done && done_strobe == 0) done_strobe = strobes;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) send_bit(v[k]);
  endtask

  task automatic pulse_start(input logic with_strobe);
    @(negedge clk);
    start      = 1'b1;
    bit_strobe = with_strobe;
    sd_data0   = 1'b0;
    @(negedge clk);
    start      = 1'b0;
    bit_strobe = 1'b0;
    sd_data0   = 1'b1;
  endtask

  task automatic make_block(input int nff, input int pat, input bit fixed_crc, input logic [15:0] crcv);
    logic [7:0]  d[$];
    logic [7:0]  v;
    logic [15:0] c;
    stream.delete();
    repeat (nff) stream.push_back(8'hFF);
    stream.push_back(8'hFE);
    for (int k = 0; k < NB; k++) begin
      v = (pat == 0) ? 8'hFF : (pat == 1) ? 8'(k) : 8'($urandom);
      d.push_back(v);
      stream.push_back(v);
    end
    c = fixed_crc ? crcv : crc_of(d);
    stream.push_back(c[15:8]);
    stream.push_back(c[7:0]);
  endtask

  task automatic run_transfer(input string tag, input logic with_strobe);
    int mism;
    model();
    cap_idx.delete();
    cap_dat.delete();
    done_cnt = 0;
    strobes = 0;
    done_strobe = 0;
    pulse_start(with_strobe);
    chk({tag, "/busy_after_start"}, busy, 1);
    chk({tag, "/status_cleared"}, {crc_ok, err_crc, err_token, err_timeout, err_code, crc_rx, crc_calc}, 0);
    foreach (stream[i]) send_byte(stream[i]);
    for (int w = 0; w < 40 && done_cnt == 0; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "/done_count"}, done_cnt, 1);
    chk({tag, "/byte_count"}, cap_dat.size(), e_dat.size());
    mism = 0;
    if (cap_dat.size() == e_dat.size())
      foreach (e_dat[k])
        if (cap_idx[k] !== 9'(k) || cap_dat[k] !== e_dat[k]) mism++;
    chk({tag, "/byte_stream_mismatches"}, mism, 0);
    chk({tag, "/crc_ok"}, crc_ok, e_kind == K_OK);
    chk({tag, "/err_crc"}, err_crc, e_kind == K_CRC);
    chk({tag, "/err_token"}, err_token, e_kind == K_TOK);
    chk({tag, "/err_timeout"}, err_timeout, e_kind == K_TMO);
    chk({tag, "/err_code"}, err_code, e_code);
    chk({tag, "/crc_rx"}, crc_rx, e_rx);
    chk({tag, "/crc_calc"}, crc_calc, e_calc);
    chk({tag, "/busy_after_done"}, busy, 0);
  endtask

  initial begin
    int mism;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {byte_out, byte_valid, byte_index, busy, done, crc_ok, err_crc,
                          err_token, err_timeout, err_code, crc_rx, crc_calc}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    make_block(2, 0, 1'b1, 16'h7FA1);
    run_transfer("ff_block_good_crc", 1'b0);

    make_block(2, 0, 1'b1, 16'h7FA0);
    run_transfer("ff_block_bad_crc", 1'b0);

    stream.delete();
    stream.push_back(8'hFF);
    stream.push_back(8'h05);
    run_transfer("token_err_05", 1'b0);
    chk("token_err_05/done_strobe", done_strobe, 16);

    stream.delete();
    repeat (100) stream.push_back(8'hFF);
    run_transfer("timeout", 1'b1);
    chk("timeout/done_strobe", done_strobe, 800);

    make_block(1, 2, 1'b1, 16'h1234);
    run_transfer("wrong_crc_1234", 1'b0);

    stream.delete();
    repeat ($urandom_range(0, 5)) stream.push_back(8'hFF);
    stream.push_back(8'($urandom_range(8'h10, 8'hFD)));
    run_transfer("token_err_rand", 1'b0);

    make_block($urandom_range(0, 6), 2, 1'b0, 16'h0000);
    run_transfer("rand_good", 1'b0);

    make_block($urandom_range(0, 6), 2, 1'b1, 16'($urandom));
    run_transfer("rand_crc", 1'b0);

    // Counting pattern, ignored re-start, then reset mid-block.
    cap_idx.delete();
    cap_dat.delete();
    done_cnt = 0;
    pulse_start(1'b0);
    send_byte(8'hFE);
    for (int i = 0; i < 200; i++) begin
      if (i == 10) begin
        pulse_start(1'b0);
        chk("restart_ignored/busy", busy, 1);
        chk("restart_ignored/status", {crc_ok, err_crc, err_token, err_timeout, done}, 0);
      end
      send_byte(8'(i));
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_block/outputs", {byte_out, byte_valid, byte_index, busy, done, crc_ok, err_crc,
                                    err_token, err_timeout, err_code, crc_rx, crc_calc}, 0);
    chk("count_pattern/byte_count", cap_dat.size(), 200);
    mism = 0;
    foreach (cap_dat[k])
      if (cap_dat[k] !== cap_idx[k][7:0] || cap_idx[k] !== 9'(k)) mism++;
    chk("count_pattern/mismatches", mism, 0);
    repeat (10) @(negedge clk);
    chk("reset_mid_block/no_done", done_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    make_block(0, 1, 1'b0, 16'h0000);
    run_transfer("after_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
